// File: rtl/rob_commit_unit_pkg.sv
// Shared ROB configuration: entry type encodings, default sizing, entry layout.
`ifndef ROB_TAG_WIDTH
`define ROB_TAG_WIDTH(size) $clog2(size)
`endif

package rob_commit_unit_pkg;

  localparam int ROB_SIZE_DEF = 8;
  localparam int TAG_W_DEF    = `ROB_TAG_WIDTH(ROB_SIZE_DEF);

  // Instruction class carried by every ROB entry; the reserved code retires like a reg write.
  typedef enum logic [1:0] {
    ROB_TYPE_REG    = 2'd0,
    ROB_TYPE_STORE  = 2'd1,
    ROB_TYPE_BRANCH = 2'd2,
    ROB_TYPE_RSVD   = 2'd3
  } rob_type_e;

  // Commit controller state: FLUSHING blocks retirement until the flush returns.
  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_FLUSHING = 1'b1
  } rob_state_e;

  typedef struct packed {
    rob_type_e   typ;
    logic [4:0]  rd;
    logic        ready;
    logic [31:0] value;
    logic        mispredict;
    logic [31:0] target;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_unit_entry_array.sv
// ROB entry storage: issue write port, writeback write port, head read port.
module rob_entry_array
  import rob_commit_unit_pkg::*;
#(
  parameter int ROB_SIZE = ROB_SIZE_DEF,
  parameter int TAG_W    = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             iss_we,
  input  logic [TAG_W-1:0] iss_idx,
  input  logic [1:0]       iss_type,
  input  logic [4:0]       iss_rd,
  input  logic             wb_we,
  input  logic [TAG_W-1:0] wb_idx,
  input  logic [31:0]      wb_value,
  input  logic             wb_mispredict,
  input  logic [31:0]      wb_target,
  input  logic [TAG_W-1:0] head_idx,
  output rob_entry_t       head_entry
);

  rob_entry_t mem_r [ROB_SIZE];

  // Entry updates: clear wipes every entry; issue and writeback never target the same occupied slot.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (wb_we) begin
        mem_r[wb_idx].ready      <= 1'b1;
        mem_r[wb_idx].value      <= wb_value;
        mem_r[wb_idx].mispredict <= wb_mispredict;
        mem_r[wb_idx].target     <= wb_target;
      end
      if (iss_we) begin
        mem_r[iss_idx].typ   <= rob_type_e'(iss_type);
        mem_r[iss_idx].rd    <= iss_rd;
        mem_r[iss_idx].ready <= 1'b0;
      end
    end
  end

  // Head read is combinational from the stored array, so a same-cycle writeback is seen next cycle.
  assign head_entry = mem_r[head_idx];

endmodule

// File: rtl/rob_commit_unit.sv
// Reorder buffer with in-order commit, store-commit pulses and mispredict flush requests.
module rob_commit_unit
  import rob_commit_unit_pkg::*;
#(
  parameter int ROB_SIZE = ROB_SIZE_DEF,
  parameter int TAG_W    = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush_in,
  input  logic             issue_valid,
  input  logic [1:0]       issue_type,
  input  logic [4:0]       issue_rd,
  output logic             full,
  output logic [TAG_W-1:0] issue_tag,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [31:0]      wb_value,
  input  logic             wb_mispredict,
  input  logic [31:0]      wb_target,
  output logic             commit_valid,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_value,
  output logic [TAG_W-1:0] commit_tag,
  output logic             store_out,
  output logic             reset_out,
  output logic [31:0]      pc_out
);

  localparam logic [TAG_W:0]   CNT_MAX  = (TAG_W+1)'(ROB_SIZE);
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W:0]   CNT_ZERO = (TAG_W+1)'(0);
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
  localparam logic [TAG_W-1:0] TAG_ZERO = TAG_W'(0);

  logic [TAG_W-1:0] head_r;
  logic [TAG_W-1:0] tail_r;
  logic [TAG_W:0]   count_r;
  logic [TAG_W:0]   count_next_s;
  rob_state_e       state_r;
  logic             full_r;

  logic             clear_s;
  logic             issue_acc_s;
  logic [TAG_W-1:0] wb_off_s;
  logic             wb_acc_s;
  logic             commit_s;
  logic             cv_s;
  logic             st_s;
  logic             ro_s;
  rob_entry_t       head_entry_s;

  logic             commit_valid_r;
  logic [4:0]       commit_rd_r;
  logic [31:0]      commit_value_r;
  logic [TAG_W-1:0] commit_tag_r;
  logic             store_out_r;
  logic             reset_out_r;
  logic [31:0]      pc_out_r;

  assign clear_s     = rst | flush_in;
  assign issue_acc_s = issue_valid & rdy & (count_r != CNT_MAX);
  // Occupied entries sit at offsets 0..count-1 from head.
  assign wb_off_s    = wb_tag - head_r;
  assign wb_acc_s    = wb_valid & rdy & ({1'b0, wb_off_s} < count_r);
  assign commit_s    = rdy & (state_r == ST_RUN) & (count_r != CNT_ZERO) & head_entry_s.ready;

  rob_entry_array #(
    .ROB_SIZE (ROB_SIZE),
    .TAG_W    (TAG_W)
  ) u_entries (
    .clk           (clk),
    .rst           (rst),
    .clr           (flush_in),
    .iss_we        (issue_acc_s),
    .iss_idx       (tail_r),
    .iss_type      (issue_type),
    .iss_rd        (issue_rd),
    .wb_we         (wb_acc_s),
    .wb_idx        (wb_tag),
    .wb_value      (wb_value),
    .wb_mispredict (wb_mispredict),
    .wb_target     (wb_target),
    .head_idx      (head_r),
    .head_entry    (head_entry_s)
  );

  // Retire decode for the head entry: which pulse(s) this commit produces.
  always_comb begin
    cv_s = 1'b0;
    st_s = 1'b0;
    ro_s = 1'b0;
    if (commit_s) begin
      case (head_entry_s.typ)
        ROB_TYPE_STORE: begin
          st_s = 1'b1;
        end
        ROB_TYPE_BRANCH: begin
          cv_s = (head_entry_s.rd != 5'd0);
          ro_s = head_entry_s.mispredict;
        end
        default: begin
          cv_s = 1'b1;
        end
      endcase
    end else begin
      cv_s = 1'b0;
    end
  end

  // Occupancy after this cycle's issue and commit.
  always_comb begin
    count_next_s = count_r;
    case ({issue_acc_s, commit_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, count, full flag and flush state; clear overrides everything, rdy=0 freezes.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      head_r  <= TAG_ZERO;
      tail_r  <= TAG_ZERO;
      count_r <= CNT_ZERO;
      full_r  <= 1'b0;
      state_r <= ST_RUN;
    end else if (rdy) begin
      if (issue_acc_s) begin
        tail_r <= tail_r + TAG_ONE;
      end
      if (commit_s) begin
        head_r <= head_r + TAG_ONE;
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_MAX);
      if (ro_s) begin
        state_r <= ST_FLUSHING;
      end
    end
  end

  // One-cycle registered retire pulses; payloads are zero whenever their strobe is low.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      commit_valid_r <= 1'b0;
      commit_rd_r    <= 5'd0;
      commit_value_r <= 32'd0;
      commit_tag_r   <= TAG_ZERO;
      store_out_r    <= 1'b0;
      reset_out_r    <= 1'b0;
      pc_out_r       <= 32'd0;
    end else begin
      commit_valid_r <= cv_s;
      commit_rd_r    <= cv_s ? head_entry_s.rd : 5'd0;
      commit_value_r <= cv_s ? head_entry_s.value : 32'd0;
      commit_tag_r   <= cv_s ? head_r : TAG_ZERO;
      store_out_r    <= st_s;
      reset_out_r    <= ro_s;
      pc_out_r       <= ro_s ? head_entry_s.target : 32'd0;
    end
  end

  assign full         = full_r;
  assign issue_tag    = tail_r;
  assign commit_valid = commit_valid_r;
  assign commit_rd    = commit_rd_r;
  assign commit_value = commit_value_r;
  assign commit_tag   = commit_tag_r;
  assign store_out    = store_out_r;
  assign reset_out    = reset_out_r;
  assign pc_out       = pc_out_r;

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Reorder-buffer queue plus in-order commit controller; drives the ROB-side inputs of the flush/commit fan-out bus: reset, redirect pc, store-commit.
- Issue side allocates entries; execution units write back by tag; head entry retires in program order.
- A mispredicted branch at the head produces a one-cycle flush pulse with the redirect pc. A store at the head produces a one-cycle store-commit pulse.

Parameters:
- ROB_SIZE, 8, entry count; power of two, at least 2.
- TAG_W, 3, log2(ROB_SIZE); entry index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; when 0, all state holds and all pulse outputs are 0
- flush_in  in  1  registered reset returned by the fan-out bus; clears queue like rst
- issue_valid  in  1  allocate request; accepted only if !full
- issue_type  in  2  0=reg write, 1=store, 2=branch, 3=reserved (treated as reg write)
- issue_rd  in  5  destination register
- full  out  1  count==ROB_SIZE (registered count, no same-cycle bypass)
- issue_tag  out  TAG_W  tail index; valid while !full
- wb_valid  in  1  writeback strobe
- wb_tag  in  TAG_W  entry being completed
- wb_value  in  32  result value
- wb_mispredict  in  1  branch resolved wrong
- wb_target  in  32  correct pc for the branch
- commit_valid  out  1  reg-write retire pulse
- commit_rd  out  5  retired destination
- commit_value  out  32  retired value
- commit_tag  out  TAG_W  retired index, for register-file tag clearing
- store_out  out  1  store-commit pulse to the load/store buffer
- reset_out  out  1  flush pulse to the fan-out bus
- pc_out  out  32  redirect pc; meaningful only when reset_out=1

Behaviour:
- Reset values (rst or flush_in): head=0, tail=0, count=0, all ready bits 0, every output 0, full=0.
- rst/flush_in have priority over issue, writeback and commit in the same cycle.
- Issue:
  - On issue_valid && !full && rdy, write entry[tail] with type, rd, ready=0.
  - Then tail = tail+1 mod ROB_SIZE (natural wrap from TAG_W bits).
  - An issue while full is ignored; no error.
- Writeback:
  - On wb_valid && rdy, set entry[wb_tag] ready=1 and store value, mispredict, target.
  - A writeback to a non-occupied entry is ignored; the occupancy check uses head, tail and count.
  - A writeback to the head lands in the same cycle but is first visible to commit next cycle; no bypass.
- Commit: at most one retire per cycle when count>0 and entry[head].ready. All outputs are registered and asserted for exactly one cycle after the decision.
  - reg write: commit_valid=1 with rd, value, tag.
  - store: store_out=1.
  - branch, no mispredict: commit_valid=1 if rd!=0, carrying value (link address).
  - branch, mispredict: reset_out=1, pc_out=target, commit_valid=1 if rd!=0. Head advances. The unit clears itself only when flush_in returns one cycle later. Between decision and flush, commit is inhibited by a flushing state bit.
- After a commit, head = head+1 mod ROB_SIZE.
- Count:
  - Simultaneous issue and commit leaves count unchanged.
  - An issue while count==ROB_SIZE-1 plus a commit keeps full=0.
  - full is derived from the registered count only.
- Flushing state:
  - States: RUN and FLUSHING.
  - RUN→FLUSHING on a mispredict commit.
  - FLUSHING→RUN on flush_in or rst.
  - In FLUSHING, issue is still accepted but is discarded by the flush.
- rdy=0: no state change; pulse outputs forced to 0 that cycle.

Decomposition:
- Shared config header (existing REG_TYPE) gains:
  - ROB_TYPE_REG, ROB_TYPE_STORE, ROB_TYPE_BRANCH encodings
  - ROB_SIZE and TAG_W defaults
  - ROB tag width macro
- One natural sub-module, rob_entry_array: storage with one write port for issue, one for writeback, and one read port at head.
- Pointer, count and FSM logic stay in rob_commit_unit.

Test Plan:
- Reset then issue 3 reg ops (rd=1,2,3); write back tags 2,0,1 with values 0x22,0x11,0x33 → commits in order rd1=0x11, rd2=0x33, rd3=0x22 on consecutive cycles; tags 0,1,2.
- Issue 8 entries → full=1; a 9th issue is ignored. Write back tag 0 → commit_valid the cycle after the ready bit is seen, full=0 next cycle, tail wraps to 0.
- Store at head, written back → store_out high exactly one cycle; commit_valid stays 0.
- Branch with rd=1, mispredict, target 0x0000_1000, at head → reset_out=1 and pc_out=0x1000 for one cycle, commit_valid with rd=1. No further commits until flush_in; after flush_in, count=0 and full=0.
- Same-cycle issue and commit at count=7 → count stays 7, full=0. Same-cycle rst and issue → count=0.
- rdy=0 while head is ready → no commit and no pointer movement. Raise rdy → commit occurs next cycle.
